mac_filtro: RTL and testbench

MAC_FILTRO -- requirements
Module: mac_filtro

---
 rtl/mac_filtro_pkg.sv | 21 ++
 rtl/mac_filtro_if.sv | 29 ++
 rtl/mac_paso.sv | 22 ++
 rtl/mac_filtro.sv | 114 +++++++++++
 tb/tb_mac_filtro.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mac_filtro_pkg.sv
// Shared definitions for the mac_filtro FIR slice: state encoding,
// Q10.14 format constants and default sizing.
package mac_filtro_pkg;

    localparam int unsigned N_DEF     = 25;
    localparam int unsigned TAPS_DEF  = 4;
    localparam int unsigned FRAC_BITS = 14;
    localparam int unsigned MAG_BITS  = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } estado_t;

    // Coefficient index width; a single-entry bank still needs one address bit.
    function automatic int unsigned addr_w(input int unsigned taps);
        return (taps > 1) ? $clog2(taps) : 1;
    endfunction

endpackage

// File: rtl/mac_filtro_if.sv
// Sample/coefficient/result bundle of mac_filtro; the filter takes the slave side.
interface mac_filtro_if
    import mac_filtro_pkg::*;
#(
    parameter int unsigned N    = N_DEF,
    parameter int unsigned TAPS = TAPS_DEF
);

    logic [N-1:0]              Dato_In;
    logic                      Listo_In;
    logic                      Coef_We;
    logic [addr_w(TAPS)-1:0]   Coef_Addr;
    logic [N-1:0]              Coef_In;
    logic [2*N-1:0]            Datos_Sum;
    logic                      Ban_List;
    logic                      Busy;
    logic                      Overrun;

    modport master (
        output Dato_In, Listo_In, Coef_We, Coef_Addr, Coef_In,
        input  Datos_Sum, Ban_List, Busy, Overrun
    );

    modport slave (
        input  Dato_In, Listo_In, Coef_We, Coef_Addr, Coef_In,
        output Datos_Sum, Ban_List, Busy, Overrun
    );

endinterface

// File: rtl/mac_paso.sv
// One multiply-accumulate step: signed N x N -> 2N product added to a
// 2N-bit accumulator, wrapping modulo 2^(2N).
module mac_paso
    import mac_filtro_pkg::*;
#(
    parameter int unsigned N = N_DEF
) (
    input  logic [N-1:0]   x,
    input  logic [N-1:0]   c,
    input  logic [2*N-1:0] acc_in,
    output logic [2*N-1:0] acc_out
);

    logic signed [2*N-1:0] prod;

    always_comb begin
        // Both operands sign-extended to full width before multiplying.
        prod    = (2*N)'($signed(x)) * (2*N)'($signed(c));
        acc_out = acc_in + prod;
    end

endmodule

// File: rtl/mac_filtro.sv
// Sequential FIR filter: one tap per cycle through a single mac_paso,
// full-precision Q20.28 result with a one-cycle Ban_List strobe.
module mac_filtro
    import mac_filtro_pkg::*;
#(
    parameter int unsigned N    = N_DEF,
    parameter int unsigned TAPS = TAPS_DEF
) (
    input  logic         clk,
    input  logic         reset,
    mac_filtro_if.slave  bus
);

    localparam int unsigned AW = addr_w(TAPS);
    localparam logic [AW-1:0] K_LAST = AW'(TAPS - 1);

    estado_t        state_q, state_d;
    logic [AW-1:0]  k_q, k_d;
    logic [2*N-1:0] acc_q, acc_d, acc_next;
    logic [2*N-1:0] datos_sum_q, datos_sum_d;
    logic           overrun_q, overrun_d;
    logic [N-1:0]   x_q [TAPS];
    logic [N-1:0]   x_d [TAPS];
    logic [N-1:0]   c_q [TAPS];
    logic [N-1:0]   c_d [TAPS];
    logic           busy;
    logic           coef_ok;

    mac_paso #(.N(N)) u_paso (
        .x       (x_q[k_q]),
        .c       (c_q[k_q]),
        .acc_in  (acc_q),
        .acc_out (acc_next)
    );

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        acc_d       = acc_q;
        datos_sum_d = datos_sum_q;
        overrun_d   = overrun_q;
        x_d         = x_q;
        c_d         = c_q;
        busy        = (state_q != IDLE);
        coef_ok     = (32'(bus.Coef_Addr) < TAPS);

        // Writes only land while idle, so a computation sees a frozen bank.
        if (bus.Coef_We && !busy && coef_ok) begin
            c_d[bus.Coef_Addr] = bus.Coef_In;
        end

        if (bus.Listo_In && busy) begin
            overrun_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (bus.Listo_In) begin
                    x_d[0] = bus.Dato_In;
                    for (int unsigned i = 1; i < TAPS; i++) begin
                        x_d[i] = x_q[i-1];
                    end
                    acc_d   = '0;
                    k_d     = '0;
                    state_d = MAC;
                end
            end
            MAC: begin
                acc_d = acc_next;
                k_d   = k_q + AW'(1);
                // Result registered on the last tap so it is already valid during DONE.
                if (k_q == K_LAST) begin
                    datos_sum_d = acc_next;
                    k_d         = '0;
                    state_d     = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            k_q         <= '0;
            acc_q       <= '0;
            datos_sum_q <= '0;
            overrun_q   <= 1'b0;
            for (int unsigned i = 0; i < TAPS; i++) begin
                x_q[i] <= '0;
                c_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            acc_q       <= acc_d;
            datos_sum_q <= datos_sum_d;
            overrun_q   <= overrun_d;
            x_q         <= x_d;
            c_q         <= c_d;
        end
    end

    assign bus.Datos_Sum = datos_sum_q;
    assign bus.Ban_List  = (state_q == DONE);
    assign bus.Busy      = busy;
    assign bus.Overrun   = overrun_q;

endmodule

// File: tb/tb_mac_filtro.sv
// Self-checking bench for mac_filtro against a plain-arithmetic FIR model.
`timescale 1ns/1ps
module tb_mac_filtro;

    localparam int unsigned N    = 25;
    localparam int unsigned TAPS = 4;
    localparam int unsigned AW   = $clog2(TAPS);
    localparam int unsigned W    = 2 * N;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mac_filtro_if #(.N(N), .TAPS(TAPS)) bus ();

    mac_filtro #(.N(N), .TAPS(TAPS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int tests_run = 0;
    int fails     = 0;

    // Reference state: the sample history and coefficient bank as the spec defines them.
    logic signed [N-1:0] x_m [TAPS];
    logic signed [N-1:0] c_m [TAPS];
    logic                ovr_m;

    function automatic logic [W-1:0] model_sum();
        longint s = 0;
        for (int i = 0; i < TAPS; i++) s += longint'(x_m[i]) * longint'(c_m[i]);
        return W'(s);
    endfunction

    task automatic model_shift(input logic signed [N-1:0] v);
        for (int i = TAPS - 1; i > 0; i--) x_m[i] = x_m[i-1];
        x_m[0] = v;
    endtask

    task automatic model_reset();
        for (int i = 0; i < TAPS; i++) begin
            x_m[i] = '0;
            c_m[i] = '0;
        end
        ovr_m = 1'b0;
    endtask

    task automatic write_coef(input int a, input logic signed [N-1:0] v);
        @(negedge clk);
        bus.Coef_We   = 1'b1;
        bus.Coef_Addr = AW'(a);
        bus.Coef_In   = v;
        @(negedge clk);
        bus.Coef_We   = 1'b0;
        c_m[a]        = v;
    endtask

    // Launches one sample and waits (bounded) for its result. Optional extra
    // Listo_In / Coef_We strobes are placed at cycle offsets after the launch.
    task automatic send_sample(input logic signed [N-1:0] v, input int inj_listo,
                               input int inj_we, input int we_addr,
                               input logic signed [N-1:0] we_val,
                               output int lat, output logic [W-1:0] sum,
                               output int busy_cnt);
        lat = -1; sum = '0; busy_cnt = 0;
        @(negedge clk);
        bus.Listo_In = 1'b1;
        bus.Dato_In  = v;
        if (inj_we == 0) begin
            bus.Coef_We   = 1'b1;
            bus.Coef_Addr = AW'(we_addr);
            bus.Coef_In   = we_val;
            c_m[we_addr]  = we_val;
        end
        model_shift(v);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (lat < 0 && bus.Busy) busy_cnt++;
            if (bus.Ban_List && lat < 0) begin
                lat = c;
                sum = bus.Datos_Sum;
            end
            bus.Listo_In  = (c == inj_listo);
            bus.Dato_In   = N'($urandom);
            bus.Coef_We   = (c == inj_we);
            bus.Coef_Addr = AW'(we_addr);
            bus.Coef_In   = we_val;
            if (c == inj_listo && c <= int'(TAPS) + 1) ovr_m = 1'b1;
            if (lat >= 0 && c > inj_listo && c > inj_we) break;
        end
        bus.Listo_In = 1'b0;
        bus.Coef_We  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.Listo_In = 1'b0; bus.Coef_We = 1'b0; bus.Dato_In = '0;
        bus.Coef_Addr = '0; bus.Coef_In = '0;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        tests_run++;
        if (bus.Datos_Sum !== '0) begin fails++; $display("FAIL reset_sum: got %0h expected 0", bus.Datos_Sum); end
        tests_run++;
        if (bus.Ban_List !== 1'b0) begin fails++; $display("FAIL reset_ban: got %b expected 0", bus.Ban_List); end
        tests_run++;
        if (bus.Busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", bus.Busy); end
        tests_run++;
        if (bus.Overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun: got %b expected 0", bus.Overrun); end
    endtask

    task automatic test_unity();
        int lat, bc;
        logic [W-1:0] s, e;
        int     samples [6] = '{16384, 32768, 0, 0, 0, 0};
        longint lit     [6] = '{268435456, 805306368, 805306368, 805306368, 536870912, 0};
        for (int i = 0; i < TAPS; i++) write_coef(i, N'(16384));
        for (int i = 0; i < 6; i++) begin
            send_sample(N'(samples[i]), -1, -1, 0, '0, lat, s, bc);
            e = model_sum();
            tests_run++;
            if (lat != int'(TAPS) + 1) begin fails++; $display("FAIL unity_latency[%0d]: got %0d expected %0d", i, lat, TAPS + 1); end
            tests_run++;
            if (bc != int'(TAPS) + 1) begin fails++; $display("FAIL unity_busy[%0d]: got %0d expected %0d", i, bc, TAPS + 1); end
            tests_run++;
            if (s !== e) begin fails++; $display("FAIL unity_model[%0d]: got %0d expected %0d", i, s, e); end
            tests_run++;
            if (s !== W'(lit[i])) begin fails++; $display("FAIL unity_const[%0d]: got %0d expected %0d", i, s, lit[i]); end
        end
        repeat (3) @(negedge clk);
        tests_run++;
        if (bus.Datos_Sum !== e) begin fails++; $display("FAIL hold_sum: got %0d expected %0d", bus.Datos_Sum, e); end
        tests_run++;
        if (bus.Ban_List !== 1'b0 || bus.Busy !== 1'b0) begin
            fails++; $display("FAIL hold_idle: got ban=%b busy=%b expected 0 0", bus.Ban_List, bus.Busy);
        end
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        logic [W-1:0] s, e;
        for (int n = 0; n < 20; n++) begin
            if ($urandom_range(1, 0) == 1) write_coef(int'($urandom_range(TAPS - 1, 0)), N'($urandom));
            send_sample(N'($urandom), -1, -1, 0, '0, lat, s, bc);
            e = model_sum();
            tests_run++;
            if (s !== e || lat != int'(TAPS) + 1) begin
                fails++; $display("FAIL random[%0d]: got %0h lat %0d expected %0h lat %0d", n, s, lat, e, TAPS + 1);
            end
        end
    endtask

    task automatic test_negative();
        int lat, bc;
        logic [W-1:0] s, e;
        write_coef(0, -N'(16384));
        for (int i = 1; i < TAPS; i++) write_coef(i, '0);
        send_sample(N'(16384), -1, -1, 0, '0, lat, s, bc);
        e = '1;
        e = e << 28;
        tests_run++;
        if (s !== e) begin fails++; $display("FAIL negative_const: got %0h expected %0h", s, e); end
        tests_run++;
        if (s !== model_sum()) begin fails++; $display("FAIL negative_model: got %0h expected %0h", s, model_sum()); end
    endtask

    task automatic test_same_cycle();
        int lat, bc;
        logic [W-1:0] s;
        logic signed [N-1:0] v = N'($urandom);
        send_sample(N'($urandom), -1, 0, 0, v, lat, s, bc);
        tests_run++;
        if (s !== model_sum()) begin fails++; $display("FAIL same_cycle_write: got %0h expected %0h", s, model_sum()); end
    endtask

    task automatic test_coef_busy();
        int lat, bc;
        logic [W-1:0] s;
        logic signed [N-1:0] v = N'($urandom) | N'(1);
        send_sample(N'($urandom), -1, 3, 1, v, lat, s, bc);
        tests_run++;
        if (s !== model_sum()) begin fails++; $display("FAIL coef_busy_result: got %0h expected %0h", s, model_sum()); end
        send_sample(N'($urandom), -1, -1, 0, '0, lat, s, bc);
        tests_run++;
        if (s !== model_sum()) begin fails++; $display("FAIL coef_busy_after: got %0h expected %0h", s, model_sum()); end
        write_coef(1, v);
        send_sample(N'($urandom), -1, -1, 0, '0, lat, s, bc);
        tests_run++;
        if (s !== model_sum()) begin fails++; $display("FAIL coef_idle_write: got %0h expected %0h", s, model_sum()); end
    endtask

    task automatic test_overrun();
        int lat, bc;
        logic [W-1:0] s;
        for (int i = 0; i < TAPS; i++) write_coef(i, N'($urandom));
        tests_run++;
        if (bus.Overrun !== 1'b0) begin fails++; $display("FAIL overrun_pre: got %b expected 0", bus.Overrun); end
        send_sample(N'($urandom), 2, -1, 0, '0, lat, s, bc);
        tests_run++;
        if (s !== model_sum() || lat != int'(TAPS) + 1) begin
            fails++; $display("FAIL overrun_mac_result: got %0h lat %0d expected %0h", s, lat, model_sum());
        end
        tests_run++;
        if (bus.Overrun !== ovr_m) begin fails++; $display("FAIL overrun_set: got %b expected %b", bus.Overrun, ovr_m); end
        send_sample(N'($urandom), int'(TAPS) + 1, -1, 0, '0, lat, s, bc);
        tests_run++;
        if (s !== model_sum()) begin fails++; $display("FAIL overrun_done_result: got %0h expected %0h", s, model_sum()); end
        send_sample(N'($urandom), -1, -1, 0, '0, lat, s, bc);
        tests_run++;
        if (s !== model_sum()) begin fails++; $display("FAIL overrun_history: got %0h expected %0h", s, model_sum()); end
        tests_run++;
        if (bus.Overrun !== ovr_m) begin fails++; $display("FAIL overrun_sticky: got %b expected %b", bus.Overrun, ovr_m); end
    endtask

    task automatic test_reset_mid();
        int lat, bc, seen;
        logic [W-1:0] s;
        @(negedge clk);
        bus.Listo_In = 1'b1;
        bus.Dato_In  = N'(16384);
        @(negedge clk);
        bus.Listo_In = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        bus.Listo_In  = 1'b1;
        bus.Coef_We   = 1'b1;
        bus.Coef_Addr = '0;
        bus.Coef_In   = N'(12345);
        @(negedge clk);
        reset = 1'b0;
        bus.Listo_In = 1'b0;
        bus.Coef_We  = 1'b0;
        model_reset();
        tests_run++;
        if (bus.Datos_Sum !== '0 || bus.Busy !== 1'b0 || bus.Ban_List !== 1'b0) begin
            fails++; $display("FAIL midreset_outputs: got sum=%0h busy=%b ban=%b expected 0 0 0", bus.Datos_Sum, bus.Busy, bus.Ban_List);
        end
        tests_run++;
        if (bus.Overrun !== 1'b0) begin fails++; $display("FAIL midreset_overrun: got %b expected 0", bus.Overrun); end
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.Ban_List) seen++;
        end
        tests_run++;
        if (seen != 0) begin fails++; $display("FAIL midreset_no_pulse: got %0d pulses expected 0", seen); end
        send_sample(N'(16384), -1, -1, 0, '0, lat, s, bc);
        tests_run++;
        if (s !== model_sum() || lat != int'(TAPS) + 1) begin
            fails++; $display("FAIL midreset_zero_result: got %0h lat %0d expected %0h", s, lat, model_sum());
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_unity();
        test_back_to_back();
        test_negative();
        test_same_cycle();
        test_coef_busy();
        test_overrun();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
